pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Consumes the MEM-stage redirect
//  (PCSrc), EX/ID register fields for load-use detection and the data-memory ready handshake.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and PC mux selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect squash, load-use bubble,
// data-memory wait freeze with timeout halt, plus saturating flush/stall counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pcsrc_mem,
    input  logic             valid_mem,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             memread_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    output logic [1:0]       pc_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned      WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_W = WCNT_W'(TIMEOUT);

    state_e            r_state;
    state_e            w_state_d;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_d;
    logic              r_halted;
    logic              w_halted_d;

    logic w_taken;
    logic w_busy;
    logic w_lu;
    logic w_flush_inc;
    logic w_stall_inc;

    assign w_taken = valid_mem & (pcsrc_mem != PCSEL_SEQ);
    assign w_busy  = valid_mem & dmem_req_mem & ~dmem_ready;
    assign w_lu    = memread_ex & (rd_ex != 5'd0) &
                     ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

    always_comb begin
        w_state_d   = r_state;
        w_wcnt_d    = r_wcnt;
        w_halted_d  = r_halted;
        w_flush_inc = 1'b0;
        w_stall_inc = 1'b0;
        pc_sel      = PCSEL_SEQ;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (r_state)
                RUN, WAIT: begin
                    if (w_busy) begin
                        w_stall_inc = 1'b1;
                        if (r_state == RUN) begin
                            w_state_d = WAIT;
                            w_wcnt_d  = WCNT_W'(1);
                        end else if (r_wcnt >= TIMEOUT_W) begin
                            w_state_d  = HALT;
                            w_halted_d = 1'b1;
                        end else begin
                            w_wcnt_d = r_wcnt + WCNT_W'(1);
                        end
                    end else begin
                        w_state_d = RUN;
                        w_wcnt_d  = '0;
                        memwb_en  = 1'b1;
                        exmem_en  = 1'b1;
                        idex_en   = 1'b1;
                        if (w_taken) begin
                            // Reserved select 11 passes through so IF can trap on it.
                            pc_sel      = pcsrc_mem;
                            pc_en       = 1'b1;
                            ifid_en     = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                            w_flush_inc = 1'b1;
                        end else if (w_lu) begin
                            idex_flush  = 1'b1;
                            w_stall_inc = 1'b1;
                        end else begin
                            pc_en   = 1'b1;
                            ifid_en = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_wcnt   <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_wcnt   <= w_wcnt_d;
            r_halted <= w_halted_d;
        end
    end

    assign halted = r_halted;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (w_flush_inc),
        .cnt (flush_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;

    // Packed control view: {pc_sel, pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en,
    // exmem_fl, memwb_en}
    localparam logic [9:0] C_NORM = 10'b00_1101_0101;
    localparam logic [9:0] C_RST  = 10'b00_0010_1010;
    localparam logic [9:0] C_LU   = 10'b00_0001_1101;
    localparam logic [9:0] C_FRZ  = 10'b00_0000_0000;
    localparam logic [9:0] M_ALL  = 10'b11_1111_1111;
    localparam logic [9:0] M_LU   = 10'b11_1110_1111;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] pcsrc;
        logic       vm;
        logic       req;
        logic       rdy;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [9:0] exp;
        logic [9:0] mask;
        logic       fi;
        logic       si;
        logic       h;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] ctl;
        logic [9:0] mask;
        logic [3:0] fc;
        logic [3:0] sc;
        logic       h;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          pcsrc_mem;
    logic                valid_mem, dmem_req_mem, dmem_ready, memread_ex;
    logic [4:0]          rd_ex, rs1_id, rs2_id;
    logic                rs1_used_id, rs2_used_id;
    logic [1:0]          pc_sel;
    logic                pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic                exmem_en, exmem_flush, memwb_en, halted;
    logic [TB_CNT_W-1:0] flush_cnt, stall_cnt;
    logic [9:0]          w_ctl;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_fc     = '0;
    logic [3:0] m_sc     = '0;
    exp_t       sb[$];
    vec_t       tbl[14];

    always #5 clk = ~clk;

    assign w_ctl = {pc_sel, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en};

    pipeline_hazard_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcsrc_mem    (pcsrc_mem),
        .valid_mem    (valid_mem),
        .dmem_req_mem (dmem_req_mem),
        .dmem_ready   (dmem_ready),
        .memread_ex   (memread_ex),
        .rd_ex        (rd_ex),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_used_id  (rs1_used_id),
        .rs2_used_id  (rs2_used_id),
        .pc_sel       (pc_sel),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_en     (memwb_en),
        .halted       (halted),
        .flush_cnt    (flush_cnt),
        .stall_cnt    (stall_cnt)
    );

    function automatic vec_t mk(string nm, logic r, logic [1:0] ps, logic vm, logic req,
                                logic rdy, logic mr, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic u1, logic u2, logic [9:0] ex,
                                logic [9:0] msk, logic fi, logic si, logic h);
        vec_t v;
        v.name = nm;  v.rst = r;   v.pcsrc = ps; v.vm = vm;   v.req = req; v.rdy = rdy;
        v.mr = mr;    v.rd = rd;   v.rs1 = rs1;  v.rs2 = rs2; v.u1 = u1;   v.u2 = u2;
        v.exp = ex;   v.mask = msk; v.fi = fi;   v.si = si;   v.h = h;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle, advance the model.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t o;
        rst          = v.rst;
        pcsrc_mem    = v.pcsrc;
        valid_mem    = v.vm;
        dmem_req_mem = v.req;
        dmem_ready   = v.rdy;
        memread_ex   = v.mr;
        rd_ex        = v.rd;
        rs1_id       = v.rs1;
        rs2_id       = v.rs2;
        rs1_used_id  = v.u1;
        rs2_used_id  = v.u2;
        e.name = v.name; e.ctl = v.exp; e.mask = v.mask; e.fc = m_fc; e.sc = m_sc; e.h = v.h;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({o.name, ".ctl"}, 32'(w_ctl & o.mask), 32'(o.ctl & o.mask));
        chk({o.name, ".flush_cnt"}, 32'(flush_cnt), 32'(o.fc));
        chk({o.name, ".stall_cnt"}, 32'(stall_cnt), 32'(o.sc));
        chk({o.name, ".halted"}, 32'(halted), 32'(o.h));
        if (v.rst) begin
            m_fc = '0;
            m_sc = '0;
        end else begin
            if (v.fi && m_fc != 4'hF) m_fc = m_fc + 4'd1;
            if (v.si && m_sc != 4'hF) m_sc = m_sc + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nrm, bsy;
        nrm = mk("normal", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 0, 0, 0);
        bsy = mk("busy", 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_FRZ, M_ALL, 0, 1, 0);

        tbl[0]  = nrm;
        tbl[1]  = mk("tk_br", 0, PCSEL_BR, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                     {PCSEL_BR, 8'hFF}, M_ALL, 1, 0, 0);
        tbl[2]  = mk("tk_jalr", 0, PCSEL_JALR, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                     {PCSEL_JALR, 8'hFF}, M_ALL, 1, 0, 0);
        tbl[3]  = mk("lu_rs2", 0, 2'b00, 0, 0, 0, 1, 5, 0, 5, 0, 1, C_LU, M_LU, 0, 1, 0);
        tbl[4]  = mk("lu_rd0", 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_NORM, M_ALL, 0, 0, 0);
        tbl[5]  = mk("lu_rs1", 0, 2'b00, 0, 0, 0, 1, 7, 7, 3, 1, 1, C_LU, M_LU, 0, 1, 0);
        tbl[6]  = mk("lu_unused", 0, 2'b00, 0, 0, 0, 1, 7, 7, 7, 0, 0, C_NORM, M_ALL, 0, 0, 0);
        tbl[7]  = mk("no_load", 0, 2'b00, 0, 0, 0, 0, 7, 7, 7, 1, 1, C_NORM, M_ALL, 0, 0, 0);
        tbl[8]  = mk("tk_rsvd", 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                     {2'b11, 8'hFF}, M_ALL, 1, 0, 0);
        tbl[9]  = mk("tk_invalid", 0, PCSEL_BR, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     C_NORM, M_ALL, 0, 0, 0);
        tbl[10] = mk("tk_and_lu", 0, PCSEL_BR, 1, 0, 0, 1, 9, 9, 0, 1, 0,
                     {PCSEL_BR, 8'hFF}, M_ALL, 1, 0, 0);
        tbl[11] = mk("busy_and_lu", 0, 2'b00, 1, 1, 0, 1, 9, 9, 0, 1, 0, C_FRZ, M_ALL, 0, 1, 0);
        tbl[12] = mk("ready_lu", 0, 2'b00, 1, 1, 1, 1, 9, 9, 0, 1, 0, C_LU, M_LU, 0, 1, 0);
        tbl[13] = mk("busy_invalid", 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                     C_NORM, M_ALL, 0, 0, 0);

        rst = 1'b1; pcsrc_mem = 2'b00; valid_mem = 0; dmem_req_mem = 0; dmem_ready = 0;
        memread_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        @(posedge clk);
        #1;

        step(mk("rst0", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, M_ALL, 0, 0, 0));
        step(mk("rst1", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, M_ALL, 0, 0, 0));
        step(nrm);

        for (int i = 0; i < 14; i++) step(tbl[i]);

        // Three busy cycles then ready: freeze, then same-cycle advance back to RUN.
        for (int i = 0; i < 3; i++) step(bsy);
        step(mk("wait_done", 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0, 0, C_NORM, M_ALL, 0, 0, 0));

        // Timeout: one RUN busy cycle plus TIMEOUT WAIT cycles, halt takes effect after.
        for (int i = 0; i < 5; i++) step(bsy);
        step(mk("halt_tk", 0, PCSEL_BR, 1, 0, 1, 0, 0, 0, 0, 0, 0, C_FRZ, M_ALL, 0, 0, 1));
        step(mk("halt_lu", 0, 2'b00, 0, 0, 0, 1, 4, 4, 0, 1, 0, C_FRZ, M_ALL, 0, 0, 1));
        step(mk("halt_rst", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, M_ALL, 0, 0, 1));
        step(nrm);

        // WAIT released by ready while a redirect sits in MEM.
        step(bsy);
        step(mk("ready_tk", 0, PCSEL_JALR, 1, 1, 1, 0, 0, 0, 0, 0, 0,
                {PCSEL_JALR, 8'hFF}, M_ALL, 1, 0, 0));

        // Reset in the middle of WAIT.
        step(bsy);
        step(bsy);
        step(mk("wait_rst", 1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_RST, M_ALL, 0, 0, 0));
        step(nrm);

        // Saturation of both counters.
        for (int i = 0; i < 18; i++) begin
            step(mk("sat_fl", 0, PCSEL_BR, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                    {PCSEL_BR, 8'hFF}, M_ALL, 1, 0, 0));
        end
        for (int i = 0; i < 18; i++) begin
            step(mk("sat_st", 0, 2'b00, 0, 0, 0, 1, 3, 3, 0, 1, 0, C_LU, M_LU, 0, 1, 0));
        end
        step(nrm);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
